// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line follower and its steering back end.
package line_follow_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_LOST  = 2'd2,
      ST_STOP  = 2'd3
   } steer_state_e;

   localparam int LINE_BINS = 16;
   localparam int CENTER_X2 = 15;
   localparam int ERR_W     = 5;

   // Doubled offset of a bin from image centre: 2*pos - 15, always odd.
   function automatic logic signed [ERR_W-1:0] line_error(input logic [3:0] pos);
      logic [ERR_W-1:0] dbl;
      dbl = {pos, 1'b0};
      return $signed(dbl - ERR_W'(CENTER_X2));
   endfunction

endpackage

// File: rtl/line_steering_pwm_steer_mix.sv
// steer_mix: combinational mapping from steering error to saturated left/right duties.
module steer_mix
   import line_follow_pkg::*;
#(
   parameter int PWM_WIDTH = 8,
   parameter int BASE_DUTY = 128,
   parameter int GAIN      = 6
) (
   input  logic signed [ERR_W-1:0]     err,
   output logic        [PWM_WIDTH-1:0] left_duty,
   output logic        [PWM_WIDTH-1:0] right_duty
);

   localparam int SUM_W = PWM_WIDTH + 8;
   localparam logic signed [SUM_W-1:0] GAIN_S   = SUM_W'(GAIN);
   localparam logic signed [SUM_W-1:0] BASE_S   = SUM_W'(BASE_DUTY);
   localparam logic signed [SUM_W-1:0] DUTY_MAX = SUM_W'((1 << PWM_WIDTH) - 1);

   logic signed [SUM_W-1:0] err_ext_s;
   logic signed [SUM_W-1:0] offset_s;
   logic signed [SUM_W-1:0] left_sum_s;
   logic signed [SUM_W-1:0] right_sum_s;

   function automatic logic [PWM_WIDTH-1:0] sat_duty(input logic signed [SUM_W-1:0] v);
      if (v[SUM_W-1]) begin
         return {PWM_WIDTH{1'b0}};
      end else if (v > DUTY_MAX) begin
         return {PWM_WIDTH{1'b1}};
      end else begin
         return v[PWM_WIDTH-1:0];
      end
   endfunction

   always_comb begin
      err_ext_s   = {{(SUM_W-ERR_W){err[ERR_W-1]}}, err};
      offset_s    = err_ext_s * GAIN_S;
      left_sum_s  = BASE_S + offset_s;
      right_sum_s = BASE_S - offset_s;
      left_duty   = sat_duty(left_sum_s);
      right_duty  = sat_duty(right_sum_s);
   end

endmodule

// File: rtl/line_steering_pwm.sv
// Frame-rate steering FSM plus free-running dual PWM for the line follower.
// Optional build macro LINE_STEER_SMOOTH_EN averages each error with the previous one.
module line_steering_pwm
   import line_follow_pkg::*;
#(
   parameter int PWM_WIDTH  = 8,
   parameter int BASE_DUTY  = 128,
   parameter int GAIN       = 6,
   parameter int MIN_EDGES  = 16,
   parameter int LOST_LIMIT = 4
) (
   input  logic             pixel_clock,
   input  logic             reset,
   input  logic             vsync,
   input  logic [3:0]       line_position,
   input  logic [15:0]      max,
   output logic             left_pwm,
   output logic             right_pwm,
   output logic [ERR_W-1:0] steer_error,
   output logic             tracking,
   output logic             stopped
);

   steer_state_e state_q, state_d;

   logic                    vsync_q;
   logic                    frame_end_s;
   logic                    frame_valid_s;
   logic [PWM_WIDTH-1:0]    count_q, count_d;
   logic [PWM_WIDTH-1:0]    pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic [PWM_WIDTH-1:0]    act_l_q, act_l_d, act_r_q, act_r_d;
   logic                    left_pwm_q, left_pwm_d, right_pwm_q, right_pwm_d;
   logic [ERR_W-1:0]        err_q, err_d;
   logic [3:0]              lost_q, lost_d;
   logic [3:0]              lost_inc_s;
   logic                    lost_limit_s;
   logic signed [ERR_W-1:0] e_raw_s;
   logic signed [ERR_W-1:0] e_used_s;
   logic [PWM_WIDTH-1:0]    mix_l_s, mix_r_s;

   assign frame_end_s   = vsync_q & ~vsync;
   assign frame_valid_s = (max >= 16'(MIN_EDGES));
   assign e_raw_s       = line_error(line_position);
   assign lost_inc_s    = lost_q + 4'd1;
   assign lost_limit_s  = (lost_inc_s >= 4'(LOST_LIMIT));

`ifdef LINE_STEER_SMOOTH_EN
   logic signed [ERR_W-1:0] e_prev_q, e_prev_d, e_base_s;
   logic        [ERR_W:0]   e_sum_s;

   // Fresh entry into TRACK averages e with itself, so no stale history leaks in.
   always_comb begin
      if (state_q == ST_IDLE || state_q == ST_STOP) begin
         e_base_s = e_raw_s;
      end else begin
         e_base_s = e_prev_q;
      end
      e_sum_s  = {e_raw_s[ERR_W-1], e_raw_s} + {e_base_s[ERR_W-1], e_base_s};
      e_used_s = e_sum_s[ERR_W:1];
   end
`else
   assign e_used_s = e_raw_s;
`endif

   steer_mix #(
      .PWM_WIDTH (PWM_WIDTH),
      .BASE_DUTY (BASE_DUTY),
      .GAIN      (GAIN)
   ) u_mix (
      .err        (e_used_s),
      .left_duty  (mix_l_s),
      .right_duty (mix_r_s)
   );

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (frame_end_s) begin
         case (state_q)
            ST_IDLE:  state_d = frame_valid_s ? ST_TRACK : ST_IDLE;
            ST_TRACK: state_d = frame_valid_s ? ST_TRACK : ST_LOST;
            ST_LOST: begin
               if (frame_valid_s) begin
                  state_d = ST_TRACK;
               end else if (lost_limit_s) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_LOST;
               end
            end
            ST_STOP:  state_d = frame_valid_s ? ST_TRACK : ST_STOP;
            default:  state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      pend_l_d = pend_l_q;
      pend_r_d = pend_r_q;
      err_d    = err_q;
      lost_d   = lost_q;
`ifdef LINE_STEER_SMOOTH_EN
      e_prev_d = e_prev_q;
`endif
      if (frame_end_s) begin
         if (frame_valid_s) begin
            pend_l_d = mix_l_s;
            pend_r_d = mix_r_s;
            err_d    = e_used_s;
            lost_d   = 4'd0;
`ifdef LINE_STEER_SMOOTH_EN
            e_prev_d = e_raw_s;
`endif
         end else begin
            case (state_q)
               ST_TRACK: lost_d = 4'd1;
               ST_LOST: begin
                  lost_d = lost_inc_s;
                  if (lost_limit_s) begin
                     pend_l_d = {PWM_WIDTH{1'b0}};
                     pend_r_d = {PWM_WIDTH{1'b0}};
                  end else begin
                     pend_l_d = pend_l_q;
                     pend_r_d = pend_r_q;
                  end
               end
               default: begin
                  pend_l_d = {PWM_WIDTH{1'b0}};
                  pend_r_d = {PWM_WIDTH{1'b0}};
               end
            endcase
         end
      end else begin
         lost_d = lost_q;
      end

      // Active duties change only at the period boundary to keep every period whole.
      count_d     = count_q + {{(PWM_WIDTH-1){1'b0}}, 1'b1};
      act_l_d     = (&count_q) ? pend_l_q : act_l_q;
      act_r_d     = (&count_q) ? pend_r_q : act_r_q;
      left_pwm_d  = (count_q < act_l_q);
      right_pwm_d = (count_q < act_r_q);
   end

   always_comb begin
      tracking    = (state_q == ST_TRACK);
      stopped     = (state_q == ST_IDLE) || (state_q == ST_STOP);
      left_pwm    = left_pwm_q;
      right_pwm   = right_pwm_q;
      steer_error = err_q;
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         vsync_q     <= 1'b0;
         count_q     <= {PWM_WIDTH{1'b0}};
         pend_l_q    <= {PWM_WIDTH{1'b0}};
         pend_r_q    <= {PWM_WIDTH{1'b0}};
         act_l_q     <= {PWM_WIDTH{1'b0}};
         act_r_q     <= {PWM_WIDTH{1'b0}};
         left_pwm_q  <= 1'b0;
         right_pwm_q <= 1'b0;
         err_q       <= {ERR_W{1'b0}};
         lost_q      <= 4'd0;
`ifdef LINE_STEER_SMOOTH_EN
         e_prev_q    <= {ERR_W{1'b0}};
`endif
      end else begin
         vsync_q     <= vsync;
         count_q     <= count_d;
         pend_l_q    <= pend_l_d;
         pend_r_q    <= pend_r_d;
         act_l_q     <= act_l_d;
         act_r_q     <= act_r_d;
         left_pwm_q  <= left_pwm_d;
         right_pwm_q <= right_pwm_d;
         err_q       <= err_d;
         lost_q      <= lost_d;
`ifdef LINE_STEER_SMOOTH_EN
         e_prev_q    <= e_prev_d;
`endif
      end
   end

endmodule
